cfg_stream_loader: RTL and testbench

Upstream configuration source for the atto-FPGA logic unit. Receives a framed configuration bitstream over a 3-wire serial link, buffers and validates it, then replays it as the unit's `cfg_in` byte stream. Each command/data pair is one cfg-in cycle after the other. No configuration byte reaches the unit unless the whole frame has passed its header, length, command and checksum checks.

---
 rtl/cfg_stream_loader.sv | 159 +++++++++++++++
 tb/tb_cfg_stream_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cfg_stream_loader.sv
// Configuration stream loader: receives a framed serial bitstream, validates
// header, length, commands and checksum, then replays cmd/data pairs on cfg_out.
module cfg_stream_loader #(
    parameter int         MAX_PAIRS = 16,
    parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       sdi,
    input  logic       cs_n,
    output logic [7:0] cfg_out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int         AW    = (MAX_PAIRS > 1) ? $clog2(2 * MAX_PAIRS) : 1;
    localparam logic [7:0] MAX_N = 8'(MAX_PAIRS);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_CNT, S_BODY, S_CSUM, S_PLAY} state_t;

    state_t     state;
    logic [1:0] rst_sync;
    logic [1:0] sck_s, sdi_s, cs_s;
    logic       sck_d, cs_d;
    logic [2:0] bit_cnt;
    logic [6:0] sh;
    logic [7:0] n_q;
    logic [7:0] csum_q;
    logic [8:0] idx_q;
    logic [8:0] pi_q;
    logic [7:0] mem [2*MAX_PAIRS];

    logic       sck_rise, cs_fall, cs_rise, bit_en, byte_vld, cmd_ok, frame_bad;
    logic [7:0] rx_byte;
    logic [8:0] two_n;

    // Reset release and serial inputs are brought into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
            sck_s    <= '0;
            sdi_s    <= '0;
            cs_s     <= 2'b11;
            sck_d    <= 1'b0;
            cs_d     <= 1'b1;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
            sck_s    <= {sck_s[0], sck};
            sdi_s    <= {sdi_s[0], sdi};
            cs_s     <= {cs_s[0], cs_n};
            sck_d    <= sck_s[1];
            cs_d     <= cs_s[1];
        end
    end

    assign sck_rise = sck_s[1] & ~sck_d;
    assign cs_fall  = ~cs_s[1] & cs_d;
    assign cs_rise  = cs_s[1] & ~cs_d;
    assign bit_en   = sck_rise & ~cs_s[1];
    assign byte_vld = bit_en & (bit_cnt == 3'd7);
    assign rx_byte  = {sh, sdi_s[1]};
    assign cmd_ok   = rx_byte[7] | (rx_byte == 8'h7F);
    assign two_n    = {n_q, 1'b0};

    always_comb begin
        frame_bad = 1'b0;
        if (byte_vld) begin
            case (state)
                S_HDR:   frame_bad = (rx_byte != HDR_BYTE);
                S_CNT:   frame_bad = (rx_byte == 8'h00) || (rx_byte > MAX_N);
                S_BODY:  frame_bad = ~idx_q[0] & ~cmd_ok;
                S_CSUM:  frame_bad = (rx_byte != csum_q);
                default: frame_bad = 1'b0;
            endcase
        end
    end

    // Datapath storage: shift register, length, running XOR and pair buffer
    always_ff @(posedge clk) begin
        if (bit_en)
            sh <= rx_byte[6:0];
        if (byte_vld && state == S_CNT) begin
            n_q    <= rx_byte;
            csum_q <= rx_byte;
        end
        if (byte_vld && state == S_BODY) begin
            csum_q                <= csum_q ^ rx_byte;
            mem[idx_q[AW-1:0]]    <= rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            idx_q   <= '0;
            pi_q    <= '0;
            cfg_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (bit_en)
                bit_cnt <= bit_cnt + 3'd1;
            case (state)
                S_IDLE: begin
                    if (cs_fall && rst_sync[1]) begin
                        state   <= S_HDR;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                S_HDR, S_CNT, S_BODY, S_CSUM: begin
                    if (cs_rise || frame_bad) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else if (byte_vld) begin
                        case (state)
                            S_HDR: state <= S_CNT;
                            S_CNT: begin
                                idx_q <= '0;
                                state <= S_BODY;
                            end
                            S_BODY: begin
                                idx_q <= idx_q + 9'd1;
                                if (idx_q == two_n - 9'd1)
                                    state <= S_CSUM;
                            end
                            default: begin
                                state   <= S_PLAY;
                                cfg_out <= mem[0];
                                pi_q    <= 9'd1;
                            end
                        endcase
                    end
                end
                S_PLAY: begin
                    // Entry already emitted entry 0; pi_q == 2N marks the end
                    if (pi_q == two_n) begin
                        cfg_out <= '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        cfg_out <= mem[pi_q[AW-1:0]];
                        pi_q    <= pi_q + 9'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed bench for cfg_stream_loader: frame table plus abort, latency and
// mid-replay reset sequences.
module tb_cfg_stream_loader;

    logic       clk = 1'b0;
    logic       rst_n, sck, sdi, cs_n;
    logic [7:0] cfg_out;
    logic       busy, done, err;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] log_q[$];
    logic       busy_q[$];
    logic       log_en = 1'b0;

    typedef struct packed {
        logic [8*36-1:0] bytes;
        logic [7:0]      len;
        logic            exp_done;
        logic            exp_err;
    } vec_t;

    vec_t tbl[9];

    cfg_stream_loader #(.MAX_PAIRS(16), .HDR_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .sdi(sdi), .cs_n(cs_n),
        .cfg_out(cfg_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (log_en) begin
            log_q.push_back(cfg_out);
            busy_q.push_back(busy);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_bit_nowait(input logic b);
        @(negedge clk);
        sdi = b;
        sck = 1'b0;
        repeat (4) @(negedge clk);
        sck = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        send_bit_nowait(b);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    function automatic logic [8*36-1:0] pk(input logic [7:0] b0, b1, b2, b3, b4, b5);
        logic [8*36-1:0] r;
        r = '0;
        r[7:0] = b0;   r[15:8] = b1;  r[23:16] = b2;
        r[31:24] = b3; r[39:32] = b4; r[47:40] = b5;
        return r;
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int         f, np, mism, nz;
        logic [7:0] e;
        log_q.delete();
        busy_q.delete();
        log_en = 1'b1;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (5) @(negedge clk);
        chk($sformatf("v%0d_start_err_clr", id), err, 0);
        chk($sformatf("v%0d_start_busy", id), busy, 1);
        for (int k = 0; k < int'(v.len); k++) send_byte(v.bytes[8*k +: 8]);
        repeat (45) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        log_en = 1'b0;
        chk($sformatf("v%0d_done", id), done, v.exp_done);
        chk($sformatf("v%0d_err", id), err, v.exp_err);
        chk($sformatf("v%0d_busy_end", id), busy, 0);
        np = v.exp_done ? int'(v.bytes[15:8]) : 0;
        f = -1;
        nz = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i] != 8'h00) begin
                nz++;
                if (f < 0) f = i;
            end
        end
        if (np == 0) begin
            chk($sformatf("v%0d_no_output", id), nz, 0);
        end else begin
            chk($sformatf("v%0d_replay_seen", id), (f >= 0) ? 1 : 0, 1);
            if (f >= 0) begin
                mism = 0;
                for (int k = 0; k < 2*np; k++) begin
                    e = v.bytes[8*(2+k) +: 8];
                    if (f + k >= log_q.size() || log_q[f+k] !== e || busy_q[f+k] !== 1'b1)
                        mism++;
                end
                for (int i = f + 2*np; i < log_q.size(); i++)
                    if (log_q[i] !== 8'h00) mism++;
                chk($sformatf("v%0d_stream", id), mism, 0);
            end
        end
    endtask

    initial begin
        int nz;
        rst_n = 1'b1; sck = 1'b0; sdi = 1'b0; cs_n = 1'b1;

        tbl[0] = '{bytes: pk(8'hA5, 8'h01, 8'h80, 8'h3C, 8'hBD, 8'h00), len: 5, exp_done: 1, exp_err: 0};
        tbl[1] = '{bytes: pk(8'hA5, 8'h01, 8'h80, 8'h3C, 8'hBC, 8'h00), len: 5, exp_done: 0, exp_err: 1};
        tbl[2] = '{bytes: pk(8'hA5, 8'h01, 8'h12, 8'h3C, 8'h2F, 8'h00), len: 5, exp_done: 0, exp_err: 1};
        tbl[3] = '{bytes: pk(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), len: 3, exp_done: 0, exp_err: 1};
        tbl[4] = '{bytes: pk(8'hA5, 8'h11, 8'h80, 8'h3C, 8'h00, 8'h00), len: 4, exp_done: 0, exp_err: 1};
        tbl[5] = '{bytes: pk(8'h5A, 8'h01, 8'h80, 8'h3C, 8'hBD, 8'h00), len: 5, exp_done: 0, exp_err: 1};
        tbl[6] = '{bytes: pk(8'hA5, 8'h02, 8'h7F, 8'h11, 8'hC0, 8'h22), len: 7, exp_done: 1, exp_err: 0};
        tbl[6].bytes[55:48] = 8'h8E;
        // 16 pairs: cmds 80..8F and data 00..0F each XOR to zero, so CSUM = N
        tbl[7] = '{bytes: pk(8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00), len: 35, exp_done: 1, exp_err: 0};
        for (int p = 0; p < 16; p++) begin
            tbl[7].bytes[8*(2+2*p) +: 8] = 8'h80 + 8'(p);
            tbl[7].bytes[8*(3+2*p) +: 8] = 8'(p);
        end
        tbl[7].bytes[8*34 +: 8] = 8'h10;
        tbl[8] = '{bytes: pk(8'hA5, 8'h01, 8'h81, 8'h00, 8'h80, 8'h00), len: 5, exp_done: 1, exp_err: 0};

        #3 rst_n = 1'b0;
        #20;
        chk("rst_cfg_out", cfg_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

        // Abort: cs_n rises after 4 bits of the second pair
        log_q.delete();
        busy_q.delete();
        log_en = 1'b1;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h80); send_byte(8'h11);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        log_en = 1'b0;
        chk("abort_err", err, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        nz = 0;
        foreach (log_q[i]) if (log_q[i] != 8'h00) nz++;
        chk("abort_no_output", nz, 0);
        run_vec(9, tbl[0]);

        // Latency and reset during replay of a 4-pair frame (CSUM = 00)
        @(negedge clk);
        cs_n = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'hA5); send_byte(8'h04);
        send_byte(8'h80); send_byte(8'h01); send_byte(8'h81); send_byte(8'h02);
        send_byte(8'h82); send_byte(8'h03); send_byte(8'h83); send_byte(8'h04);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit_nowait(1'b0);
        @(negedge clk); chk("lat_cyc1", cfg_out, 8'h00);
        @(negedge clk); chk("lat_cyc2", cfg_out, 8'h00);
        @(negedge clk); chk("play0", cfg_out, 8'h80);
        @(negedge clk); chk("play1", cfg_out, 8'h01);
        @(negedge clk); chk("play2", cfg_out, 8'h81);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cfg_out", cfg_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err, 0);
        cs_n = 1'b1;
        sck = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nz = 0;
        repeat (40) begin
            @(negedge clk);
            if (cfg_out != 8'h00 || busy) nz++;
        end
        chk("post_rst_quiet", nz, 0);
        chk("post_rst_done", done, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
